// File: rtl/tdoa_pkg.sv
// Shared encodings for the TDOA capture controller: FSM states,
// timing-counter select commands and the default counter width.
package tdoa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ARMED = 2'b01,
        COUNT = 2'b10,
        DONE  = 2'b11
    } tdoa_state_e;

    localparam logic [1:0] SEL_CLEAR = 2'b00;
    localparam logic [1:0] SEL_HOLD  = 2'b01;
    localparam logic [1:0] SEL_INC   = 2'b11;

    localparam int CNT_W_DEF = 20;

endpackage

// File: rtl/tdoa_ch_latch.sv
// Per-channel arrival latch: records the first trigger seen while capture
// is enabled and ignores every later assertion until cleared.
module tdoa_ch_latch #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             cap_en,
    input  logic             trig,
    input  logic [CNT_W-1:0] value,
    output logic             valid,
    output logic [CNT_W-1:0] ts
);

    // First-arrival capture; clr wipes the result for a new acquisition.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            valid <= 1'b0;
            ts    <= '0;
        end else if (cap_en && trig && !valid) begin
            valid <= 1'b1;
            ts    <= value;
        end
    end

endmodule

// File: rtl/tdoa_capture_ctrl.sv
// TDOA capture controller. Drives the shared timing counter, waits for the
// first comparator trigger, then timestamps each channel's first arrival
// until every channel has arrived or the capture window runs out.
//
//   state | meaning
//   IDLE  | counter cleared, waiting for arm
//   ARMED | results cleared, waiting for the first channel trigger
//   COUNT | counter running, latching per-channel arrival times
//   DONE  | counter held, results stable until re-armed
module tdoa_capture_ctrl
    import tdoa_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = 100000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      abort,
    input  logic [NUM_CH-1:0]         ch_trig,
    input  logic [CNT_W-1:0]          counter_value,
    output logic [1:0]                counter_sel,
    output logic                      busy,
    output logic                      done,
    output logic                      timeout,
    output logic [NUM_CH-1:0]         ch_valid,
    output logic [$clog2(NUM_CH)-1:0] first_ch,
    output logic [NUM_CH*CNT_W-1:0]   ts_flat
);

    localparam int FC_W = $clog2(NUM_CH);

    tdoa_state_e       state, state_nxt;
    logic [NUM_CH-1:0] valid;
    logic              any_trig, all_after, win_exp;
    logic              clr, cap_en, timeout_set;
    logic [CNT_W-1:0]  cap_value;

    function automatic logic [FC_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        logic [FC_W-1:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (v[i]) r = FC_W'(i);
        end
        return r;
    endfunction

    assign any_trig  = |ch_trig;
    assign all_after = &(valid | ch_trig);
    assign win_exp   = (counter_value == CNT_W'(WINDOW - 1));
    // The starting channels see the counter before it has counted, so force 0.
    assign cap_value = (state == ARMED) ? '0 : counter_value;

    // Next state, counter command and capture/clear strobes.
    always_comb begin
        state_nxt   = state;
        counter_sel = SEL_CLEAR;
        clr         = 1'b0;
        cap_en      = 1'b0;
        timeout_set = 1'b0;
        case (state)
            IDLE: begin
                if (arm) begin
                    state_nxt = ARMED;
                    clr       = 1'b1;
                end
            end
            ARMED: begin
                cap_en = 1'b1;
                if (any_trig) begin
                    counter_sel = SEL_INC;
                    state_nxt   = (&ch_trig) ? DONE : COUNT;
                end
            end
            COUNT: begin
                counter_sel = SEL_INC;
                cap_en      = 1'b1;
                if (all_after) begin
                    state_nxt = DONE;
                end else if (win_exp) begin
                    state_nxt   = DONE;
                    timeout_set = 1'b1;
                end
            end
            DONE: begin
                // Re-arming also zeroes the held count so a trigger in the very
                // first ARMED cycle still sees the counter start from zero.
                counter_sel = arm ? SEL_CLEAR : SEL_HOLD;
                if (arm) begin
                    state_nxt = ARMED;
                    clr       = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt   = IDLE;
            clr         = 1'b1;
            cap_en      = 1'b0;
            timeout_set = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Acquisition-wide results: starting channel and window-expiry flag.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            first_ch <= '0;
            timeout  <= 1'b0;
        end else begin
            if (state == ARMED && any_trig) first_ch <= lowest_set(ch_trig);
            if (timeout_set)                timeout  <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tdoa_ch_latch #(.CNT_W(CNT_W)) u_latch (
            .clk    (clk),
            .reset  (reset),
            .clr    (clr),
            .cap_en (cap_en),
            .trig   (ch_trig[i]),
            .value  (cap_value),
            .valid  (valid[i]),
            .ts     (ts_flat[i*CNT_W +: CNT_W])
        );
    end

    assign ch_valid = valid;
    assign busy     = (state == ARMED) || (state == COUNT);
    assign done     = (state == DONE);

endmodule

// File: tb/tb_tdoa_capture_ctrl.sv
// Bench for tdoa_capture_ctrl with a behavioural timing counter. Expected
// results come from arrival offsets relative to the first trigger.
module tb_tdoa_capture_ctrl;

    localparam int NCH = 4;
    localparam int CW  = 20;
    localparam int W   = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [NCH-1:0]    ch_trig = '0;
    logic [CW-1:0]     counter_value = '0;
    logic [1:0]        counter_sel;
    logic              busy, done, timeout;
    logic [NCH-1:0]    ch_valid;
    logic [1:0]        first_ch;
    logic [NCH*CW-1:0] ts_flat;

    int checks   = 0;
    int failures = 0;

    tdoa_capture_ctrl #(.NUM_CH(NCH), .CNT_W(CW), .WINDOW(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .arm           (arm),
        .abort         (abort),
        .ch_trig       (ch_trig),
        .counter_value (counter_value),
        .counter_sel   (counter_sel),
        .busy          (busy),
        .done          (done),
        .timeout       (timeout),
        .ch_valid      (ch_valid),
        .first_ch      (first_ch),
        .ts_flat       (ts_flat)
    );

    always #5 clk = ~clk;

    // Shared timing counter: clear / hold / increment on select.
    always @(posedge clk) begin
        case (counter_sel)
            2'b00:   counter_value <= '0;
            2'b11:   counter_value <= counter_value + 1'b1;
            default: counter_value <= counter_value;
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    64'(busy), 64'd0);
        chk({tag, "_done"},    64'(done), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
        chk({tag, "_valid"},   64'(ch_valid), 64'd0);
        chk({tag, "_first"},   64'(first_ch), 64'd0);
        chk({tag, "_tszero"},  64'(ts_flat == '0), 64'd1);
        chk({tag, "_sel"},     64'(counter_sel), 64'd0);
    endtask

    // Called in ARMED; off[i] = cycles after the first trigger at which
    // channel i arrives (-1 = never). Exactly the min offset must be 0.
    task automatic run_capture(input int off[NCH], input bit hold, input int arm_at,
                               input string tag);
        bit exp_v[NCH];
        bit all_v;
        int mx, dc, fc;
        all_v = 1'b1;
        mx    = 0;
        fc    = -1;
        for (int i = 0; i < NCH; i++) begin
            exp_v[i] = (off[i] >= 0) && (off[i] < W);
            all_v    = all_v && exp_v[i];
            if (exp_v[i] && off[i] > mx) mx = off[i];
            if (off[i] == 0 && fc < 0) fc = i;
        end
        dc = all_v ? mx + 1 : W;
        for (int k = 0; k < W + 3; k++) begin
            for (int i = 0; i < NCH; i++)
                ch_trig[i] = hold ? (off[i] >= 0 && k >= off[i]) : (k == off[i]);
            arm = (k == arm_at);
            #1;
            chk($sformatf("%s_done_k%0d", tag, k), 64'(done), 64'(k >= dc));
            chk($sformatf("%s_busy_k%0d", tag, k), 64'(busy), 64'(k < dc));
            chk($sformatf("%s_sel_k%0d", tag, k), 64'(counter_sel),
                (k < dc) ? 64'd3 : 64'd1);
            tick();
        end
        ch_trig = '0;
        arm     = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 64'(ch_valid[i]), 64'(exp_v[i]));
            chk($sformatf("%s_ts%0d", tag, i), 64'(ts_flat[i*CW +: CW]),
                exp_v[i] ? 64'(off[i]) : 64'd0);
        end
        chk({tag, "_first"},   64'(first_ch), 64'(fc));
        chk({tag, "_timeout"}, 64'(timeout), 64'(!all_v));
    endtask

    initial begin
        int o[NCH];
        int w;
        bit h;

        tick();
        tick();
        reset = 1'b0;
        chk_idle("reset");

        // basic staggered capture
        do_arm();
        chk("armed_busy", 64'(busy), 64'd1);
        chk("armed_sel", 64'(counter_sel), 64'd0);
        tick();
        o = '{3, 9, 0, 5};
        run_capture(o, 1'b0, -1, "basic");

        // simultaneous first pair, trigger in the first ARMED cycle
        do_arm();
        o = '{4, 0, 6, 0};
        run_capture(o, 1'b1, -1, "simul");

        // window expiry with a capture on the last cycle
        do_arm();
        tick();
        o = '{0, -1, 15, -1};
        run_capture(o, 1'b0, -1, "tmo");

        // held trigger and an ignored arm mid-COUNT
        do_arm();
        o = '{0, 10, 12, 8};
        run_capture(o, 1'b1, 4, "repeat");
        do_arm();
        chk("rearm_valid", 64'(ch_valid), 64'd0);
        chk("rearm_busy", 64'(busy), 64'd1);
        chk("rearm_done", 64'(done), 64'd0);
        chk("rearm_sel", 64'(counter_sel), 64'd0);
        chk("rearm_timeout", 64'(timeout), 64'd0);

        // all channels on the same cycle
        o = '{0, 0, 0, 0};
        run_capture(o, 1'b0, -1, "all4");

        // abort in COUNT
        do_arm();
        ch_trig = 4'b0100;
        for (int k = 0; k < 5; k++) tick();
        chk("pre_abort_first", 64'(first_ch), 64'd2);
        chk("pre_abort_busy", 64'(busy), 64'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_idle("abort");
        ch_trig = '0;
        tick();
        chk("abort_cnt_clear", 64'(counter_value), 64'd0);

        // reset while ARMED
        do_arm();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk_idle("rst_armed");

        // randomized arrivals
        for (int n = 0; n < 25; n++) begin
            do_arm();
            w = int'($urandom_range(0, 2));
            for (int k = 0; k < w; k++) tick();
            for (int i = 0; i < NCH; i++)
                o[i] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, W + 2));
            o[$urandom_range(0, NCH - 1)] = 0;
            h = 1'($urandom_range(0, 1));
            run_capture(o, h, -1, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
